// File: rtl/mcpu_loader_defs.sv
// ---------------------------------------------------------------------------
// mcpu_loader_defs : shared state encoding and image-format constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mcpu_loader_defs;

   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
   localparam int         HDR_LEN       = 3;
   localparam int         CHK_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHK    = 3'd4,
      ST_RUN    = 3'd5,
      ST_ERROR  = 3'd6
   } ld_state_e;

endpackage

`default_nettype wire

// File: rtl/mcpu_prog_mem.sv
// ---------------------------------------------------------------------------
// mcpu_prog_mem : byte-wide program memory, sync write, async range-checked read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcpu_prog_mem #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [31:0]       raddr_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Out-of-range fetches return 00 ("mov pc,pc") so a runaway core parks itself.
   always_comb begin
      rdata_o = 8'h00;
      if (raddr_i[31:ADDR_W] == '0) rdata_o = mem_q[raddr_i[ADDR_W-1:0]];
   end

endmodule

`default_nettype wire

// File: rtl/mcpu_prog_loader.sv
// ---------------------------------------------------------------------------
// mcpu_prog_loader : streams a program image into memory and gates core reset
// Optional checksum byte enabled by MCPU_LOADER_CHECKSUM_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcpu_prog_loader
   import mcpu_loader_defs::*;
#(
   parameter int         ADDR_W = 10,
   parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] rom_addr,
   output logic [7:0]  rom_value,
   output logic        core_reset,
   output logic        running,
   output logic        load_err
);

   localparam logic [16:0] MEM_BYTES = 17'd1 << ADDR_W;
`ifdef MCPU_LOADER_CHECKSUM_EN
   localparam ld_state_e ST_AFTER_DATA = ST_CHK;
`else
   localparam ld_state_e ST_AFTER_DATA = ST_RUN;
`endif

   ld_state_e         state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              core_reset_q, running_q, load_err_q;
   logic              mem_we;
   logic              accept;
   logic [15:0]       len_full;
`ifdef MCPU_LOADER_CHECKSUM_EN
   logic [CHK_W-1:0]  sum_q, sum_d;
`endif

   assign in_ready = ~reset;
   assign accept   = in_valid & in_ready;
   assign len_full = {in_data, len_q[7:0]};

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      mem_we  = 1'b0;
`ifdef MCPU_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (accept) begin
         case (state_q)
            ST_LEN_LO: begin
               len_d[7:0] = in_data;
               state_d    = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               len_d   = len_full;
               count_d = '0;
               if (len_full == 16'd0)                 state_d = ST_AFTER_DATA;
               else if ({1'b0, len_full} > MEM_BYTES) state_d = ST_ERROR;
               else                                   state_d = ST_DATA;
            end
            ST_DATA: begin
               mem_we  = 1'b1;
               count_d = count_q + 1'b1;
`ifdef MCPU_LOADER_CHECKSUM_EN
               sum_d   = sum_q + in_data;
`endif
               if (16'(count_q) == len_q - 16'd1) state_d = ST_AFTER_DATA;
            end
`ifdef MCPU_LOADER_CHECKSUM_EN
            ST_CHK: state_d = ((sum_q + in_data) == 8'h00) ? ST_RUN : ST_ERROR;
`endif
            default: begin
               // IDLE, RUN and ERROR all resynchronise on MAGIC; IDLE also rejects anything else.
               if (in_data == MAGIC) begin
                  state_d = ST_LEN_LO;
`ifdef MCPU_LOADER_CHECKSUM_EN
                  sum_d   = '0;
`endif
               end else if (state_q == ST_IDLE) begin
                  state_d = ST_ERROR;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         count_q      <= '0;
         core_reset_q <= 1'b1;
         running_q    <= 1'b0;
         load_err_q   <= 1'b0;
`ifdef MCPU_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         count_q      <= count_d;
         core_reset_q <= (state_d != ST_RUN);
         running_q    <= (state_d == ST_RUN);
         load_err_q   <= (state_d == ST_ERROR);
`ifdef MCPU_LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign core_reset = core_reset_q;
   assign running    = running_q;
   assign load_err   = load_err_q;

   mcpu_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (count_q[ADDR_W-1:0]),
      .wdata_i (in_data),
      .raddr_i (rom_addr),
      .rdata_o (rom_value)
   );

endmodule

`default_nettype wire
